csr_access_unit: RTL and testbench

Sequencer between the execute stage and the CSR register file. Accepts one csrrd/csrwr/csrxchg operation at a time over a valid/ready handshake, reads the old CSR value, performs the masked write for csrxchg, and hands the old value to writeback. It is the only driver of the CSR file's read-address and write ports.

---
 rtl/csr_access_unit.sv | 140 ++++++++++++++
 tb/tb_csr_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences csrrd/csrwr/csrxchg between execute and the CSR file.
// Accepts one operation at a time, reads the old CSR value, performs the (masked)
// write, and hands the old value to writeback.
// Optional feature macro: CSR_ACCESS_PRIV_CHECK_EN -- when defined, an operation
// accepted at a nonzero privilege level skips the CSR file and responds with an
// IPE exception one cycle after accept.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a new operation
// S_READ  | CSR read address driven, old value captured at the clock edge
// S_WRITE | single-cycle write strobe for csrwr / csrxchg
// S_RESP  | result offered to writeback, held until out_ready
module csr_access_unit #(
  parameter int CSR_ADDR_W = 14,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [1:0]            i_in_op,
  input  logic [CSR_ADDR_W-1:0] i_in_csr_num,
  input  logic [DATA_W-1:0]     i_in_rd_val,
  input  logic [DATA_W-1:0]     i_in_rj_mask,
  input  logic [4:0]            i_in_rd_idx,
  input  logic [1:0]            i_cur_plv,
  input  logic                  i_flush,
  output logic [CSR_ADDR_W-1:0] o_csr_raddr,
  input  logic [DATA_W-1:0]     i_csr_rdata,
  output logic                  o_csr_wr_en,
  output logic [CSR_ADDR_W-1:0] o_csr_waddr,
  output logic [DATA_W-1:0]     o_csr_wdata,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [4:0]            o_out_rd_idx,
  output logic [DATA_W-1:0]     o_out_rd_wdata,
  output logic                  o_out_rd_we,
  output logic                  o_out_excp
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_op;
  logic [CSR_ADDR_W-1:0] r_num;
  logic [DATA_W-1:0]     r_rd_val;
  logic [DATA_W-1:0]     r_mask;
  logic [DATA_W-1:0]     r_old;
  logic [4:0]            r_rd_idx;
  logic                  r_excp;
  logic                  w_accept;
  logic                  w_priv_fault;

  // A flush in IDLE suppresses the offer even though in_ready stays high.
  assign w_accept = (r_state == S_IDLE) && i_in_valid && !i_flush;

`ifdef CSR_ACCESS_PRIV_CHECK_EN
  assign w_priv_fault = (i_cur_plv != 2'd0);
`else
  logic w_unused_plv;
  assign w_unused_plv = ^i_cur_plv;
  assign w_priv_fault = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake/strobe decode; flush abandons any non-idle state.
  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_csr_wr_en = 1'b0;
    o_out_valid = 1'b0;
    o_out_rd_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (w_accept) w_next = w_priv_fault ? S_RESP : S_READ;
      end
      S_READ: begin
        if (i_flush)      w_next = S_IDLE;
        else if (r_op[1]) w_next = S_WRITE;
        else              w_next = S_RESP;
      end
      S_WRITE: begin
        o_csr_wr_en = !i_flush;
        w_next      = i_flush ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (i_flush) begin
          w_next = S_IDLE;
        end else begin
          o_out_valid = 1'b1;
          o_out_rd_we = (r_rd_idx != 5'd0) && !r_excp;
          if (i_out_ready) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch at accept; old value captured at the end of READ.
  // r_old is cleared at accept so an exception response carries zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= 2'b00;
      r_num    <= '0;
      r_rd_val <= '0;
      r_mask   <= '0;
      r_old    <= '0;
      r_rd_idx <= 5'd0;
      r_excp   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= i_in_op;
        r_num    <= i_in_csr_num;
        r_rd_val <= i_in_rd_val;
        r_mask   <= i_in_rj_mask;
        r_old    <= '0;
        r_rd_idx <= i_in_rd_idx;
        r_excp   <= w_priv_fault;
      end
      if (r_state == S_READ) r_old <= i_csr_rdata;
    end
  end

  assign o_csr_raddr    = r_num;
  assign o_csr_waddr    = r_num;
  assign o_csr_wdata    = (r_op == 2'b10) ? r_rd_val
                                          : ((r_rd_val & r_mask) | (r_old & ~r_mask));
  assign o_out_rd_idx   = r_rd_idx;
  assign o_out_rd_wdata = r_old;
  assign o_out_excp     = r_excp;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed testbench for csr_access_unit with a behavioural CSR file.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_val;
  logic [31:0] in_rj_mask;
  logic [4:0]  in_rd_idx;
  logic [1:0]  cur_plv;
  logic        flush;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wr_en;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd_idx;
  logic [31:0] out_rd_wdata;
  logic        out_rd_we;
  logic        out_excp;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses = 0;

  logic [31:0] csr_mem [0:16383];

  csr_access_unit #(.CSR_ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(in_op),
    .i_in_csr_num(in_csr_num), .i_in_rd_val(in_rd_val), .i_in_rj_mask(in_rj_mask),
    .i_in_rd_idx(in_rd_idx), .i_cur_plv(cur_plv), .i_flush(flush),
    .o_csr_raddr(csr_raddr), .i_csr_rdata(csr_rdata), .o_csr_wr_en(csr_wr_en),
    .o_csr_waddr(csr_waddr), .o_csr_wdata(csr_wdata),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_rd_idx(out_rd_idx),
    .o_out_rd_wdata(out_rd_wdata), .o_out_rd_we(out_rd_we), .o_out_excp(out_excp)
  );

  always #5 clk = ~clk;

  assign csr_rdata = csr_mem[csr_raddr];

  always @(posedge clk) begin
    if (csr_wr_en === 1'b1) begin
      csr_mem[csr_waddr] <= csr_wdata;
      wr_pulses <= wr_pulses + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one accepting edge; returns in cycle T+1.
  task automatic offer(input logic [1:0] op, input logic [13:0] num,
                       input logic [31:0] rd_val, input logic [31:0] mask,
                       input logic [4:0] idx);
    in_valid   = 1'b1;
    in_op      = op;
    in_csr_num = num;
    in_rd_val  = rd_val;
    in_rj_mask = mask;
    in_rd_idx  = idx;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (csr_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b exp 0", csr_wr_en); end
    n_tests++; if (csr_raddr !== 14'h0 || csr_waddr !== 14'h0) begin n_fail++; $display("FAIL reset_addr got r=%h w=%h exp 0", csr_raddr, csr_waddr); end
    n_tests++; if (csr_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", csr_wdata); end
    n_tests++; if (out_rd_wdata !== 32'h0 || out_rd_idx !== 5'd0 || out_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_out_rd got wdata=%h idx=%0d we=%b exp 0", out_rd_wdata, out_rd_idx, out_rd_we); end
    n_tests++; if (out_excp !== 1'b0) begin n_fail++; $display("FAIL reset_excp got %b exp 0", out_excp); end
  endtask

  task automatic test_csrrd();
    int w0;
    csr_mem[14'h5] = 32'hABCD0000;
    w0 = wr_pulses;
    out_ready = 1'b1;
    offer(2'b01, 14'h5, 32'h0, 32'h0, 5'd4);
    n_tests++; if (out_valid !== 1'b0 || csr_raddr !== 14'h5) begin n_fail++; $display("FAIL rd_t1 got valid=%b raddr=%h exp 0/5", out_valid, csr_raddr); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rd_t1_ready got %b exp 0", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rd_t2_valid got %b exp 1", out_valid); end
    n_tests++; if (out_rd_wdata !== 32'hABCD0000) begin n_fail++; $display("FAIL rd_data got %h exp abcd0000", out_rd_wdata); end
    n_tests++; if (out_rd_we !== 1'b1 || out_rd_idx !== 5'd4) begin n_fail++; $display("FAIL rd_we_idx got we=%b idx=%0d exp 1/4", out_rd_we, out_rd_idx); end
    step();
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_done got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    n_tests++; if (wr_pulses !== w0) begin n_fail++; $display("FAIL rd_no_write got %0d pulses exp 0", wr_pulses - w0); end
  endtask

  task automatic test_csrxchg();
    csr_mem[14'h30] = 32'hFFFF0000;
    out_ready = 1'b1;
    offer(2'b11, 14'h30, 32'h12345678, 32'h0000FFFF, 5'd7);
    n_tests++; if (csr_wr_en !== 1'b0) begin n_fail++; $display("FAIL xchg_t1_wr got %b exp 0", csr_wr_en); end
    step();
    n_tests++; if (csr_wr_en !== 1'b1) begin n_fail++; $display("FAIL xchg_t2_wr got %b exp 1", csr_wr_en); end
    n_tests++; if (csr_wdata !== 32'hFFFF5678 || csr_waddr !== 14'h30) begin n_fail++; $display("FAIL xchg_wdata got %h @%h exp ffff5678 @30", csr_wdata, csr_waddr); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL xchg_t2_valid got %b exp 0", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b1 || csr_wr_en !== 1'b0) begin n_fail++; $display("FAIL xchg_t3 got valid=%b wr=%b exp 1/0", out_valid, csr_wr_en); end
    n_tests++; if (out_rd_wdata !== 32'hFFFF0000) begin n_fail++; $display("FAIL xchg_old got %h exp ffff0000", out_rd_wdata); end
    n_tests++; if (csr_mem[14'h30] !== 32'hFFFF5678) begin n_fail++; $display("FAIL xchg_mem got %h exp ffff5678", csr_mem[14'h30]); end
    step();
  endtask

  task automatic test_backpressure();
    csr_mem[14'h10] = 32'h11112222;
    out_ready = 1'b0;
    offer(2'b10, 14'h10, 32'hCAFEF00D, 32'h0, 5'd0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_rd_wdata !== 32'h11112222 || out_rd_we !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%h we=%b ready=%b exp 1/11112222/0/0", i, out_valid, out_rd_wdata, out_rd_we, in_ready);
      end
      step();
    end
    n_tests++; if (csr_mem[14'h10] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bp_mem got %h exp cafef00d", csr_mem[14'h10]); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_flush();
    int w0;
    csr_mem[14'h20] = 32'h55555555;
    w0 = wr_pulses;
    out_ready = 1'b1;
    offer(2'b10, 14'h20, 32'h00000000, 32'h0, 5'd3);
    step();
    flush = 1'b1;
    #1;
    n_tests++; if (csr_wr_en !== 1'b0) begin n_fail++; $display("FAIL flush_wr got %b exp 0", csr_wr_en); end
    step();
    flush = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b0 || wr_pulses !== w0 || csr_mem[14'h20] !== 32'h55555555) begin n_fail++; $display("FAIL flush_effect got valid=%b pulses=%0d mem=%h exp 0/0/55555555", out_valid, wr_pulses - w0, csr_mem[14'h20]); end
    // Flush while idle: offer ignored, unit stays idle.
    flush = 1'b1;
    offer(2'b01, 14'h5, 32'h0, 32'h0, 5'd1);
    flush = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_offer got ready=%b exp 1", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_resp got valid=%b exp 0", out_valid); end
  endtask

  task automatic test_priv();
    int w0;
    csr_mem[14'h0] = 32'h00000077;
    w0 = wr_pulses;
    out_ready = 1'b1;
    cur_plv = 2'd3;
    offer(2'b10, 14'h0, 32'hDEADBEEF, 32'h0, 5'd9);
    cur_plv = 2'd0;
`ifdef CSR_ACCESS_PRIV_CHECK_EN
    n_tests++; if (out_valid !== 1'b1 || out_excp !== 1'b1) begin n_fail++; $display("FAIL priv_t1 got valid=%b excp=%b exp 1/1", out_valid, out_excp); end
    n_tests++; if (out_rd_we !== 1'b0 || out_rd_wdata !== 32'h0) begin n_fail++; $display("FAIL priv_data got we=%b data=%h exp 0/0", out_rd_we, out_rd_wdata); end
    step();
    n_tests++; if (wr_pulses !== w0 || csr_mem[14'h0] !== 32'h00000077) begin n_fail++; $display("FAIL priv_nowrite got pulses=%0d mem=%h exp 0/77", wr_pulses - w0, csr_mem[14'h0]); end
`else
    step();
    n_tests++; if (csr_wr_en !== 1'b1) begin n_fail++; $display("FAIL nopriv_wr got %b exp 1", csr_wr_en); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_excp !== 1'b0) begin n_fail++; $display("FAIL nopriv_resp got valid=%b excp=%b exp 1/0", out_valid, out_excp); end
    n_tests++; if (out_rd_wdata !== 32'h00000077 || out_rd_we !== 1'b1) begin n_fail++; $display("FAIL nopriv_data got %h we=%b exp 77/1", out_rd_wdata, out_rd_we); end
    step();
    n_tests++; if (csr_mem[14'h0] !== 32'hDEADBEEF || wr_pulses !== w0 + 1) begin n_fail++; $display("FAIL nopriv_mem got %h pulses=%0d exp deadbeef/1", csr_mem[14'h0], wr_pulses - w0); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) csr_mem[i] = 32'h0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_csr_num = 14'h0;
    in_rd_val  = 32'h0;
    in_rj_mask = 32'h0;
    in_rd_idx  = 5'd0;
    cur_plv    = 2'd0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    test_reset();
    test_csrrd();
    test_csrxchg();
    test_backpressure();
    test_flush();
    test_priv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
